// File: rtl/axi_stream_header_extract.sv
// axi_stream_header_extract
//   Strips a 0..DATA_BYTE_WD byte header from the front of each AXI-Stream packet.
//   The header goes out on its own channel, right-aligned. The remaining payload is
//   realigned so that its first byte sits in the top lane (lane DATA_BYTE_WD-1 is
//   the first byte on the wire).
//
// Ports
//   clk, rst_n                               clock, asynchronous active-low reset
//   valid_strip, byte_strip_cnt, ready_strip per-packet strip command
//   valid_in, data_in, keep_in, last_in      input stream (ready_in out)
//   valid_hdr, data_hdr, keep_hdr            extracted header (ready_hdr in)
//   valid_out, data_out, keep_out, last_out  realigned payload (ready_out in)
module axi_stream_header_extract #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    byte_strip_cnt,
    output logic                    ready_strip,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
);

    localparam int unsigned CW = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {StIdle, StFirst, StBody, StFlush} state_e;

    state_e                    state_q;
    logic [CW-1:0]             strip_cnt_q;
    logic [DATA_WD-1:0]        resid_q;      // leftover bytes, packed into the top lanes
    logic [DATA_BYTE_WD-1:0]   flush_keep_q;

    logic [DATA_WD-1:0] beat;               // data_in with invalid lanes zeroed
    logic [DATA_WD-1:0] body_data;
    logic [DATA_WD-1:0] next_resid;
    int unsigned        keep_cnt, c_num, res_num, tot_num, hdr_num, cmd_num;
    logic               out_free, in_fire, body_fire;

    // Mask with the top n bits set (n may equal DATA_BYTE_WD).
    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input int unsigned n);
        logic [DATA_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    // Mask with the low n bits set (n may equal DATA_BYTE_WD).
    function automatic logic [DATA_BYTE_WD-1:0] low_mask(input int unsigned n);
        logic [DATA_BYTE_WD-1:0] ones;
        ones = '1;
        return ~(ones << n);
    endfunction

    always_comb begin
        beat     = '0;
        keep_cnt = 0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            keep_cnt += 32'(keep_in[i]);
            beat[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
        end
        cmd_num = (32'(byte_strip_cnt) > DATA_BYTE_WD) ? DATA_BYTE_WD : 32'(byte_strip_cnt);
        c_num   = 32'(strip_cnt_q);
        res_num = (c_num == 0) ? 0 : DATA_BYTE_WD - c_num;
        tot_num = res_num + keep_cnt;
        // A short last first-beat only carries keep_cnt header bytes.
        hdr_num = (last_in && keep_cnt < c_num) ? keep_cnt : c_num;
        body_data  = resid_q | (beat >> (8 * res_num));
        next_resid = (res_num == 0) ? '0 : (beat << (8 * c_num));
    end

    assign out_free    = !valid_out || ready_out;
    assign ready_strip = (state_q == StIdle);
    assign ready_in    = ((state_q == StFirst) || (state_q == StBody)) && out_free &&
                         ((state_q != StFirst) || (c_num == 0) || !valid_hdr || ready_hdr);
    assign in_fire     = valid_in && ready_in;
    // With c=0 the first beat takes the plain pass-through path.
    assign body_fire   = in_fire && ((state_q == StBody) || (c_num == 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            strip_cnt_q  <= '0;
            resid_q      <= '0;
            flush_keep_q <= '0;
            valid_hdr    <= 1'b0;
            data_hdr     <= '0;
            keep_hdr     <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
        end else begin
            if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;
            if (valid_out && ready_out) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (valid_strip) begin
                        strip_cnt_q <= CW'(cmd_num);
                        resid_q     <= '0;
                        state_q     <= StFirst;
                    end
                end
                StFirst, StBody: begin
                    if (body_fire) begin
                        valid_out <= 1'b1;
                        data_out  <= body_data;
                        resid_q   <= next_resid;
                        if (!last_in) begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                            state_q  <= StBody;
                        end else if (tot_num <= DATA_BYTE_WD) begin
                            keep_out <= top_mask(tot_num);
                            last_out <= 1'b1;
                            state_q  <= StIdle;
                        end else begin
                            keep_out     <= '1;
                            last_out     <= 1'b0;
                            flush_keep_q <= top_mask(tot_num - DATA_BYTE_WD);
                            state_q      <= StFlush;
                        end
                    end else if (in_fire) begin
                        // First beat with a header to strip.
                        valid_hdr <= 1'b1;
                        data_hdr  <= beat >> (8 * (DATA_BYTE_WD - hdr_num));
                        keep_hdr  <= low_mask(hdr_num);
                        resid_q   <= next_resid;
                        if (!last_in) begin
                            state_q <= StBody;
                        end else begin
                            if (keep_cnt > c_num) begin
                                valid_out <= 1'b1;
                                data_out  <= beat << (8 * c_num);
                                keep_out  <= top_mask(keep_cnt - c_num);
                                last_out  <= 1'b1;
                            end
                            state_q <= StIdle;
                        end
                    end
                end
                StFlush: begin
                    if (out_free) begin
                        valid_out <= 1'b1;
                        data_out  <= resid_q;
                        keep_out  <= flush_keep_q;
                        last_out  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
